// File: rtl/cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module  : cpu_step_controller
// Brief   : Execute-enable sequencer for the single-cycle MIPS datapath
//           (free-run / single-step, input stall, halt latch, retire count).
// Revision: 1.0 - initial release
// ============================================================================
module cpu_step_controller #(
    parameter int DIV_W = 26,
    parameter int DIV0  = 50_000_000,
    parameter int DIV1  = 12_500_000,
    parameter int DIV2  = 1_000_000,
    parameter int DIV3  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_run,
    input  logic [1:0]  div_sel,
    input  logic        step_btn,
    input  logic        instr_in,
    input  logic        instr_out,
    input  logic        halt,
    output logic        cpu_en,
    output logic        out_strobe,
    output logic        waiting_in,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_STEP       = 2'd1,
        S_INPUT_WAIT = 2'd2,
        S_HALTED     = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] c_last0 = DIV_W'(DIV0 - 1);
    localparam logic [DIV_W-1:0] c_last1 = DIV_W'(DIV1 - 1);
    localparam logic [DIV_W-1:0] c_last2 = DIV_W'(DIV2 - 1);
    localparam logic [DIV_W-1:0] c_last3 = DIV_W'(DIV3 - 1);

    state_t             r_state;
    state_t             w_next_state;
    state_t             w_mode_state;
    logic               r_btn_q;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   w_div_next;
    logic [DIV_W-1:0]   w_last;
    logic               w_tick;
    logic               w_press;
    logic               w_trig;
    logic               w_fire;
    logic               r_cpu_en;
    logic               r_out_strobe;
    logic               r_waiting_in;
    logic               r_halted;
    logic [31:0]        r_retired;

    always_comb begin
        w_last = c_last3;
        case (div_sel)
            2'd0:    w_last = c_last0;
            2'd1:    w_last = c_last1;
            2'd2:    w_last = c_last2;
            default: w_last = c_last3;
        endcase
    end

    // ">=" so that shrinking the period mid-count still ticks on the next cycle
    assign w_tick  = (r_div >= w_last);
    assign w_press = step_btn & ~r_btn_q;

    always_comb begin
        w_next_state = r_state;
        w_fire       = 1'b0;
        w_trig       = 1'b0;
        w_mode_state = mode_run ? S_RUN : S_STEP;
        case (r_state)
            S_RUN, S_STEP: begin
                w_trig       = (r_state == S_RUN) ? w_tick : w_press;
                w_next_state = w_mode_state;
                if (w_trig) begin
                    if (halt) begin
                        w_next_state = S_HALTED;
                    end else if (instr_in) begin
                        w_next_state = S_INPUT_WAIT;
                    end else begin
                        w_fire = 1'b1;
                    end
                end
            end
            S_INPUT_WAIT: begin
                if (w_press) begin
                    w_fire       = 1'b1;
                    w_next_state = w_mode_state;
                end
            end
            default: w_next_state = S_HALTED;
        endcase
    end

    // Divider only runs while staying in RUN; any other path parks it at zero
    assign w_div_next = (r_state == S_RUN && w_next_state == S_RUN && !w_tick)
                        ? r_div + DIV_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= mode_run ? S_RUN : S_STEP;
            r_btn_q      <= 1'b0;
            r_div        <= '0;
            r_cpu_en     <= 1'b0;
            r_out_strobe <= 1'b0;
            r_waiting_in <= 1'b0;
            r_halted     <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_state      <= w_next_state;
            r_btn_q      <= step_btn;
            r_div        <= w_div_next;
            r_cpu_en     <= w_fire;
            r_out_strobe <= w_fire & instr_out;
            r_waiting_in <= (w_next_state == S_INPUT_WAIT);
            r_halted     <= (w_next_state == S_HALTED);
            if (w_fire) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign cpu_en     = r_cpu_en;
    assign out_strobe = r_out_strobe;
    assign waiting_in = r_waiting_in;
    assign halted     = r_halted;
    assign retired    = r_retired;

endmodule
`default_nettype wire
